serial_adder_ctrl: RTL and testbench



---
 rtl/serial_adder_pkg.sv | 14 +
 rtl/serial_adder_ctrl_fa.sv | 15 +
 rtl/serial_adder_ctrl.sv | 133 +++++++++++++
 tb/tb_serial_adder_ctrl.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared types and defaults for the bit-serial adder.
//   sa_state_e : controller state encoding (IDLE, RUN, DONE), 2 bits
//   SA_WIDTH   : default operand/result width
package serial_adder_pkg;

  localparam int SA_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sa_state_e;

endpackage

// File: rtl/serial_adder_ctrl_fa.sv
// serial_fa_bit: combinational 1-bit full adder slice, no state.
//   a, b, cin : input bits
//   sum, cout : sum bit and carry out
module serial_fa_bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial adder controller. Sequences one serial_fa_bit
// slice over WIDTH cycles, LSB first, to compute {cout,sum} = a + b + cin.
//   clk, rst_n      : clock (rising edge), async active-low reset
//   start           : request, sampled only while ready
//   a, b, cin       : operands, captured on the accepted start
//   sub             : (SERIAL_ADDER_SUB_EN only) subtract a - b; cin ignored
//   ready/busy/done : IDLE / RUN / one-cycle completion pulse
//   sum, cout       : registered result, held until the next completion
// Optional feature macro: SERIAL_ADDER_SUB_EN adds the sub port.
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = SA_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CNT_W = $clog2(WIDTH);

  sa_state_e        state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             carry_q, carry_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;

  logic             fa_sum, fa_cout;
  logic [WIDTH-1:0] b_cap;
  logic             c_cap;

  // Subtract is a + ~b + 1: invert b and force the initial carry.
`ifdef SERIAL_ADDER_SUB_EN
  assign b_cap = sub ? ~b : b;
  assign c_cap = sub ? 1'b1 : cin;
`else
  assign b_cap = b;
  assign c_cap = cin;
`endif

  serial_fa_bit u_fa (
    .a    (a_sh_q[0]),
    .b    (b_sh_q[0]),
    .cin  (carry_q),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    res_d   = res_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ready   = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      IDLE: begin
        ready = 1'b1;
        if (start) begin
          a_sh_d  = a;
          b_sh_d  = b_cap;
          carry_d = c_cap;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        busy    = 1'b1;
        res_d   = {fa_sum, res_q[WIDTH-1:1]};
        carry_d = fa_cout;
        a_sh_d  = a_sh_q >> 1;
        b_sh_d  = b_sh_q >> 1;
        cnt_d   = cnt_q + CNT_W'(1);
        // Publish on the last bit only, so partial results never reach sum.
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          sum_d   = {fa_sum, res_q[WIDTH-1:1]};
          cout_d  = fa_cout;
          state_d = DONE;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
module tb_serial_adder_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] a = '0, b = '0;
  logic       cin = 1'b0;
  logic       sub = 1'b0;
  logic       ready, busy, done, cout;
  logic [7:0] sum;

  logic       start4 = 1'b0;
  logic [3:0] a4 = '0, b4 = '0;
  logic       cin4 = 1'b0;
  logic       sub4 = 1'b0;
  logic       ready4, busy4, done4, cout4;
  logic [3:0] sum4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_adder_ctrl #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin),
`ifdef SERIAL_ADDER_SUB_EN
    .sub(sub),
`endif
    .ready(ready), .busy(busy), .done(done), .sum(sum), .cout(cout)
  );

  serial_adder_ctrl #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4), .cin(cin4),
`ifdef SERIAL_ADDER_SUB_EN
    .sub(sub4),
`endif
    .ready(ready4), .busy(busy4), .done(done4), .sum(sum4), .cout(cout4)
  );

  // Drive one 8-bit op and wait (bounded) for done; lat=-1 on timeout.
  task automatic op8(input logic [7:0] ta, input logic [7:0] tb_, input logic tc,
                     output int lat);
    a = ta; b = tb_; cin = tc; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (done) begin lat = i; break; end
    end
  endtask

  task automatic test_reset;
    #1;
    checks++;
    if ({ready, busy, done, cout, sum} !== {3'b100, 9'h000}) begin
      errors++;
      $display("FAIL reset_hold: got rdy=%b busy=%b done=%b cout=%b sum=%h, want 1 0 0 0 00",
               ready, busy, done, cout, sum);
    end
    @(posedge clk); #1; rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({ready, busy, done} !== 3'b100) begin
      errors++;
      $display("FAIL reset_release: got rdy=%b busy=%b done=%b, want 1 0 0", ready, busy, done);
    end
  endtask

  task automatic test_basic;
    int lat;
    a = 8'h5A; b = 8'h3C; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    checks++;
    if ({ready, busy} !== 2'b01) begin
      errors++;
      $display("FAIL basic_ready_drop: got rdy=%b busy=%b, want 0 1", ready, busy);
    end
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (done) begin lat = i; break; end
    end
    checks++;
    if (lat !== 8) begin
      errors++;
      $display("FAIL basic_latency: got %0d, want 8", lat);
    end
    checks++;
    if ({cout, sum} !== 9'h096) begin
      errors++;
      $display("FAIL basic_result: got cout=%b sum=%h, want 0 96", cout, sum);
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if ({done, ready, cout, sum} !== {2'b01, 9'h096}) begin
        errors++;
        $display("FAIL basic_hold: got done=%b rdy=%b cout=%b sum=%h, want 0 1 0 96",
                 done, ready, cout, sum);
      end
    end
  endtask

  task automatic test_back_to_back;
    int lat;
    a = 8'hFF; b = 8'h01; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (done) begin lat = i; break; end
    end
    checks++;
    if (lat !== 8 || {cout, sum} !== 9'h100) begin
      errors++;
      $display("FAIL b2b_first: got lat=%0d cout=%b sum=%h, want 8 1 00", lat, cout, sum);
    end
    a = 8'hFF; b = 8'hFF; cin = 1'b1;  // start still high
    @(posedge clk); #1;
    checks++;
    if (ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_idle: got rdy=%b, want 1", ready);
    end
    @(posedge clk); #1; start = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_accept: got busy=%b, want 1", busy);
    end
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (done) begin lat = i; break; end
    end
    checks++;
    if (lat !== 8 || {cout, sum} !== 9'h1FF) begin
      errors++;
      $display("FAIL b2b_second: got lat=%0d cout=%b sum=%h, want 8 1 ff", lat, cout, sum);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_ignore_start;
    int ndone;
    logic [8:0] res;
    a = 8'h12; b = 8'h34; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    a = 8'hAA; b = 8'h55; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    ndone = 0; res = 'x;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (done) begin ndone++; res = {cout, sum}; end
    end
    checks++;
    if (ndone !== 1) begin
      errors++;
      $display("FAIL ignore_done_count: got %0d, want 1", ndone);
    end
    checks++;
    if (res !== 9'h046) begin
      errors++;
      $display("FAIL ignore_result: got %h, want 046", res);
    end
  endtask

  task automatic test_reset_midop;
    int ndone, lat;
    a = 8'h80; b = 8'h80; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({ready, busy, done, cout, sum} !== {3'b100, 9'h000}) begin
      errors++;
      $display("FAIL midop_reset: got rdy=%b busy=%b done=%b cout=%b sum=%h, want 1 0 0 0 00",
               ready, busy, done, cout, sum);
    end
    @(posedge clk); #1; rst_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    checks++;
    if (ndone !== 0) begin
      errors++;
      $display("FAIL midop_no_done: got %0d dones, want 0", ndone);
    end
    op8(8'h80, 8'h80, 1'b0, lat);
    checks++;
    if (lat !== 8 || {cout, sum} !== 9'h100) begin
      errors++;
      $display("FAIL midop_rerun: got lat=%0d cout=%b sum=%h, want 8 1 00", lat, cout, sum);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_exhaustive4;
    logic [4:0] prev, exp;
    int lat;
    prev = '0;
    for (int ia = 0; ia < 16; ia++)
      for (int ib = 0; ib < 16; ib++)
        for (int ic = 0; ic < 2; ic++) begin
          a4 = 4'(ia); b4 = 4'(ib); cin4 = 1'(ic); start4 = 1'b1;
          exp = 5'(ia + ib + ic);
          @(posedge clk); #1; start4 = 1'b0;
          checks++;
          if ({cout4, sum4} !== prev) begin
            errors++;
            $display("FAIL ex4_stable a=%0d b=%0d c=%0d: got %h, want %h", ia, ib, ic,
                     {cout4, sum4}, prev);
          end
          lat = -1;
          for (int i = 1; i <= 10; i++) begin
            @(posedge clk); #1;
            if (done4) begin lat = i; break; end
          end
          checks++;
          if (lat !== 4 || {cout4, sum4} !== exp) begin
            errors++;
            $display("FAIL ex4_result a=%0d b=%0d c=%0d: got lat=%0d res=%h, want 4 %h",
                     ia, ib, ic, lat, {cout4, sum4}, exp);
          end
          @(posedge clk); #1;
          checks++;
          if (done4 !== 1'b0) begin
            errors++;
            $display("FAIL ex4_pulse a=%0d b=%0d c=%0d: done still %b, want 0", ia, ib, ic, done4);
          end
          prev = exp;
        end
  endtask

`ifdef SERIAL_ADDER_SUB_EN
  task automatic test_sub;
    int lat;
    sub = 1'b1;
    op8(8'h10, 8'h01, 1'b0, lat);
    checks++;
    if (lat !== 8 || {cout, sum} !== 9'h10F) begin
      errors++;
      $display("FAIL sub_10_01: got lat=%0d cout=%b sum=%h, want 8 1 0f", lat, cout, sum);
    end
    @(posedge clk); #1;
    op8(8'h00, 8'h01, 1'b0, lat);
    checks++;
    if (lat !== 8 || {cout, sum} !== 9'h0FF) begin
      errors++;
      $display("FAIL sub_00_01: got lat=%0d cout=%b sum=%h, want 8 0 ff", lat, cout, sum);
    end
    @(posedge clk); #1;
    op8(8'h10, 8'h01, 1'b1, lat);
    checks++;
    if (lat !== 8 || {cout, sum} !== 9'h10F) begin
      errors++;
      $display("FAIL sub_cin_ignored: got lat=%0d cout=%b sum=%h, want 8 1 0f", lat, cout, sum);
    end
    @(posedge clk); #1;
    sub = 1'b0;
    op8(8'h10, 8'h01, 1'b1, lat);
    checks++;
    if (lat !== 8 || {cout, sum} !== 9'h012) begin
      errors++;
      $display("FAIL sub_off_add: got lat=%0d cout=%b sum=%h, want 8 0 12", lat, cout, sum);
    end
    @(posedge clk); #1;
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_ignore_start();
    test_reset_midop();
    test_exhaustive4();
`ifdef SERIAL_ADDER_SUB_EN
    test_sub();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
